sha3_block_padder: RTL and testbench
====================================

# sha3_block_padder

Message-ingest stage directly upstream of the Keccak absorb stage in the SHA3-256 core. It accepts the message as a stream of 64-bit little-endian words with a valid/ready handshake and packs 17 words into one 1088-bit rate block. It applies SHA3 pad10*1 padding (domain byte 0x06, final bit 0x80) to the last block. Each completed block is presented on a valid/ready output that the absorb stage consumes as its `block` input.

## Interface
- RATE_WORDS, 17: 64-bit words per rate block (1088 bits).
- WORD_W, 64: input word width.

- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- in_valid  in  1  input word present.
- in_ready  out  1  block can accept a word; equals (state == FILL).
- in_data  in  64  message bytes; byte k of the word at bits [8k+7:8k].
- in_last  in  1  this word is the final word of the message.
- in_bytes  in  4  valid bytes in a last word, 0..8. Ignored unless in_last. Values >8 are treated as 8.
- block_out  out  1088  rate block; word i at bits [64i+63:64i], block byte p at bits [8p+7:8p].
- block_valid  out  1  block_out holds a complete block.
- block_ready  in  1  downstream accepts the block.
- block_last  out  1  block_out is the final (padded) block of the message.

## Operation
- A transfer occurs on a rising clk edge where valid and ready are both high, on either side.
- State FILL:
  - Word counter cnt runs 0..16. An accepted word is stored at word slot cnt.
  - Non-last word with cnt<16: cnt++.
  - Non-last word with cnt==16: go to FULL with block_last=0.
- Accepted last word, with b = in_bytes and p = 8*cnt + b (block byte index, 0..136):
  - Bytes of the word at index ≥b are forced to 0.
  - If p<136: byte p |= 0x06, byte 135 |= 0x80 (p==135 gives 0x86). Go to FULL with block_last=1.
  - If p==136 (17th word, 8 bytes): go to FULL with block_last=0 and set pad_pending.
- State FULL:
  - block_valid=1 and in_ready=0.
  - On block_ready with pad_pending: load the pad-only block (byte0=0x06, byte135=0x80, rest 0). Set block_last=1, clear pad_pending, stay in FULL.
  - On block_ready without pad_pending: clear block_out, block_last=0 and cnt=0; go to FILL.
- Empty message (last word at cnt=0 with b=0) yields a single pad-only block with block_last=1.
- block_out is cleared to 0 whenever the block returns to FILL, so unwritten bytes are always 0.
- Back-to-back messages: the word after a last word begins a new message at cnt=0.

## Timing
- Reset (asynchronous, takes effect immediately): state=FILL, cnt=0, pad_pending=0, block_out=0, block_valid=0, block_last=0. Consequently in_ready=1.
- block_valid rises on the edge that accepts the completing word, so it is visible in the next cycle. Latency is 1 cycle.
- block_out and block_last are registered and stay stable while block_valid=1 and block_ready=0.
- block_valid drops on the edge where block_ready is sampled high. The only exception is a pad_pending handoff, where block_valid stays 1 with new contents on the next cycle.
- in_ready returns to 1 in the cycle after the handoff. Peak throughput is one block per 18 cycles (17 words + 1 handoff).
- Reset asserted mid-fill or mid-FULL discards the partial or pending block. No output is produced for it.

## Test plan
- Empty message: after reset, drive in_valid=1, in_last=1, in_bytes=0 for one cycle.
  - Next cycle: block_valid=1, block_last=1, byte0=0x06, byte135=0x80, all other bytes 0.
- "abc": one word with in_data=0x0000000000636261, in_last=1, in_bytes=3.
  - Required: bytes0..2 = 61 62 63, byte3=0x06, byte135=0x80, block_last=1.
- 135-byte message: 16 full words, then a last word with in_bytes=7.
  - Required: byte135=0x86, block_last=1, single block.
- 136-byte message: 17 full words, in_last on the 17th.
  - First block: the data with block_last=0.
  - After block_ready: the pad-only block (0x06/0x80) with block_last=1, block_valid held continuously.
  - Then in_ready=1.
- Backpressure: complete a block and hold block_ready=0 for 10 cycles.
  - Required: in_ready=0 and block_out/block_last unchanged throughout; handoff on the first block_ready=1 edge.
- Reset mid-fill: accept 5 words, then pulse reset asynchronously between edges.
  - Required: outputs 0 immediately, in_ready=1.
  - A following "abc" message produces exactly the block from the "abc" scenario.

Source files
------------

// File: rtl/sha3_block_padder.sv
// sha3_block_padder: packs 64-bit LE message words into 1088-bit SHA3-256
// rate blocks and applies pad10*1 (domain 0x06, final bit 0x80).
//
// Ports:
//   clk, reset          rising-edge clock, async active-high reset
//   in_valid/in_ready   input word handshake (in_ready high while filling)
//   in_data             message word, byte k at bits [8k+7:8k]
//   in_last, in_bytes   final word marker and its valid byte count (0..8)
//   block_out           rate block, byte p at bits [8p+7:8p]
//   block_valid/ready   output block handshake toward the absorb stage
//   block_last          block_out is the final padded block of a message
module sha3_block_padder #(
    parameter int RATE_WORDS = 17,
    parameter int WORD_W     = 64
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WORD_W-1:0]            in_data,
    input  logic                         in_last,
    input  logic [3:0]                   in_bytes,
    output logic [RATE_WORDS*WORD_W-1:0] block_out,
    output logic                         block_valid,
    input  logic                         block_ready,
    output logic                         block_last
);

    localparam int BLK_W      = RATE_WORDS * WORD_W;
    localparam int RATE_BYTES = BLK_W / 8;

    localparam logic [4:0] LAST_SLOT  = 5'(RATE_WORDS - 1);
    localparam logic [7:0] RATE_B8    = 8'(RATE_BYTES);

    // Pad-only block: used for empty-tail messages whose data filled the
    // whole rate exactly, leaving no room for the padding bytes.
    localparam logic [BLK_W-1:0] PAD_BLK =
        {8'h80, {(BLK_W - 16){1'b0}}, 8'h06};

    typedef enum logic {
        FILL,
        FULL
    } state_t;

    state_t           state;
    logic [4:0]       cnt;
    logic             pad_pending;

    logic [3:0]       b_eff;
    logic [WORD_W-1:0] word_m;
    logic [7:0]       byte_pos;
    logic             pad_fits;
    logic [BLK_W-1:0] blk_fill;

    assign in_ready = (state == FILL);

    // Next block contents if the presented word is accepted this cycle.
    always_comb begin
        b_eff    = (in_bytes > 4'd8) ? 4'd8 : in_bytes;
        word_m   = in_data;
        if (in_last) begin
            for (int k = 0; k < 8; k++) begin
                if (4'(k) >= b_eff) begin
                    word_m[8*k +: 8] = 8'h00;
                end
            end
        end
        byte_pos = {cnt, 3'b000} + {4'b0000, b_eff};
        pad_fits = (byte_pos < RATE_B8);
        blk_fill = block_out;
        blk_fill[{cnt, 6'b000000} +: WORD_W] = word_m;
        // Domain byte lands either inside this word or at the start of an
        // untouched (already zero) later slot; both OR cleanly.
        if (in_last && pad_fits) begin
            blk_fill[{byte_pos, 3'b000} +: 8] =
                blk_fill[{byte_pos, 3'b000} +: 8] | 8'h06;
            blk_fill[BLK_W-1 -: 8] = blk_fill[BLK_W-1 -: 8] | 8'h80;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= FILL;
            cnt         <= 5'd0;
            pad_pending <= 1'b0;
            block_out   <= '0;
            block_valid <= 1'b0;
            block_last  <= 1'b0;
        end else begin
            unique case (state)
                FILL: begin
                    if (in_valid) begin
                        block_out <= blk_fill;
                        if (in_last) begin
                            state       <= FULL;
                            block_valid <= 1'b1;
                            block_last  <= pad_fits;
                            pad_pending <= !pad_fits;
                        end else if (cnt == LAST_SLOT) begin
                            state       <= FULL;
                            block_valid <= 1'b1;
                            block_last  <= 1'b0;
                        end else begin
                            cnt <= cnt + 5'd1;
                        end
                    end
                end
                FULL: begin
                    if (block_ready) begin
                        if (pad_pending) begin
                            block_out   <= PAD_BLK;
                            block_last  <= 1'b1;
                            pad_pending <= 1'b0;
                        end else begin
                            block_out   <= '0;
                            block_last  <= 1'b0;
                            block_valid <= 1'b0;
                            cnt         <= 5'd0;
                            state       <= FILL;
                        end
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_sha3_block_padder.sv
// tb_sha3_block_padder: scoreboard bench for sha3_block_padder.
// Expected padded blocks come from a byte-level pad10*1 model.
module tb_sha3_block_padder;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [63:0]   in_data;
    logic          in_last;
    logic [3:0]    in_bytes;
    logic [1087:0] block_out;
    logic          block_valid;
    logic          block_ready;
    logic          block_last;

    sha3_block_padder dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .in_bytes    (in_bytes),
        .block_out   (block_out),
        .block_valid (block_valid),
        .block_ready (block_ready),
        .block_last  (block_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1087:0] data;
        logic          last;
    } blk_t;

    blk_t          sbq[$];
    byte unsigned  msg[$];
    int            checks   = 0;
    int            failures = 0;
    int            blk_n    = 0;
    bit            rnd_ready = 1'b0;
    blk_t          mon_e;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference padding: append 0x06 at L, 0x80 at the final rate byte.
    task automatic push_exp(input int len);
        int nb;
        int nblk;
        byte unsigned pb[];
        blk_t e;
        nb   = (len / 136 + 1) * 136;
        nblk = nb / 136;
        pb   = new[nb];
        for (int i = 0; i < nb; i++) pb[i] = 8'h00;
        for (int i = 0; i < len; i++) pb[i] = msg[i];
        pb[len]  = pb[len] ^ 8'h06;
        pb[nb-1] = pb[nb-1] ^ 8'h80;
        for (int b = 0; b < nblk; b++) begin
            e.data = '0;
            for (int p = 0; p < 136; p++) e.data[8*p +: 8] = pb[b*136 + p];
            e.last = (b == nblk - 1);
            sbq.push_back(e);
        end
    endtask

    task automatic rand_msg(input int len);
        msg.delete();
        repeat (len) msg.push_back(8'($urandom));
    endtask

    task automatic send(input int len, input bit junk);
        int nw;
        int b;
        int to;
        logic [63:0] d;
        nw = (len == 0) ? 1 : (len + 7) / 8;
        push_exp(len);
        for (int w = 0; w < nw; w++) begin
            b = (w == nw - 1) ? len - 8 * w : 8;
            for (int k = 0; k < 8; k++)
                d[8*k +: 8] = (k < b) ? msg[8*w + k] :
                              (junk ? 8'($urandom) : 8'h00);
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = d;
            in_last  = (w == nw - 1);
            if (w != nw - 1)
                in_bytes = 4'($urandom_range(0, 15));
            else if (b == 8 && junk)
                in_bytes = 4'($urandom_range(8, 15));
            else
                in_bytes = 4'(b);
            to = 0;
            while (!in_ready && to < 300) begin
                @(negedge clk);
                to++;
            end
            if (to >= 300) chk("in_ready_to", 64'(in_ready), 64'd1);
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("latency", 64'(block_valid), 64'd1);
    endtask

    task automatic drain();
        int to;
        to = 0;
        while (sbq.size() != 0 && to < 2000) begin
            @(negedge clk);
            to++;
        end
        chk("drain", 64'(sbq.size()), 64'd0);
    endtask

    always @(negedge clk) begin
        if (!reset && block_valid && block_ready) begin
            if (sbq.size() == 0) begin
                chk("extra_blk", 64'd1, 64'd0);
            end else begin
                mon_e = sbq.pop_front();
                for (int w = 0; w < 17; w++)
                    chk($sformatf("b%0d_w%0d", blk_n, w),
                        block_out[64*w +: 64], mon_e.data[64*w +: 64]);
                chk($sformatf("b%0d_last", blk_n),
                    64'(block_last), 64'(mon_e.last));
            end
            blk_n++;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_ready) block_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        int n0;
        reset       = 1'b1;
        in_valid    = 1'b0;
        in_data     = '0;
        in_last     = 1'b0;
        in_bytes    = '0;
        block_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_valid", 64'(block_valid), 64'd0);
        chk("rst_last", 64'(block_last), 64'd0);
        chk("rst_blk", 64'(|block_out), 64'd0);
        reset = 1'b0;
        @(posedge clk);
        #1 block_ready = 1'b1;

        rand_msg(0);
        send(0, 1'b0);
        drain();

        msg.delete();
        msg.push_back(8'h61);
        msg.push_back(8'h62);
        msg.push_back(8'h63);
        send(3, 1'b0);
        drain();

        n0 = blk_n;
        rand_msg(135);
        send(135, 1'b1);
        drain();
        chk("n135_blocks", 64'(blk_n - n0), 64'd1);

        @(posedge clk);
        #1 block_ready = 1'b0;
        rand_msg(136);
        send(136, 1'b1);
        repeat (10) begin
            @(negedge clk);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_valid", 64'(block_valid), 64'd1);
            chk("bp_last", 64'(block_last), 64'd0);
            chk("bp_hold", 64'(block_out == sbq[0].data), 64'd1);
        end
        @(posedge clk);
        #1 block_ready = 1'b1;
        @(posedge clk);
        #1 block_ready = 1'b0;
        @(negedge clk);
        chk("pad_valid_held", 64'(block_valid), 64'd1);
        chk("pad_last", 64'(block_last), 64'd1);
        chk("pad_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1 block_ready = 1'b1;
        @(posedge clk);
        #1 block_ready = 1'b0;
        @(negedge clk);
        chk("post_in_ready", 64'(in_ready), 64'd1);
        chk("post_valid", 64'(block_valid), 64'd0);
        drain();

        rnd_ready = 1'b1;
        foreach (msg[i]) msg[i] = msg[i];
        rand_msg(1);   send(1, 1'b1);
        rand_msg(8);   send(8, 1'b1);
        rand_msg(100); send(100, 1'b1);
        rand_msg(137); send(137, 1'b1);
        rand_msg(272); send(272, 1'b1);
        rand_msg(300); send(300, 1'b1);
        drain();
        rnd_ready = 1'b0;

        @(posedge clk);
        #1 block_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 64'({$urandom, $urandom});
            in_last  = 1'b0;
            @(posedge clk);
        end
        #3 reset = 1'b1;
        #1;
        chk("mid_rst_valid", 64'(block_valid), 64'd0);
        chk("mid_rst_rdy", 64'(in_ready), 64'd1);
        chk("mid_rst_blk", 64'(|block_out), 64'd0);
        chk("mid_rst_last", 64'(block_last), 64'd0);
        in_valid = 1'b0;
        reset    = 1'b0;
        msg.delete();
        msg.push_back(8'h61);
        msg.push_back(8'h62);
        msg.push_back(8'h63);
        send(3, 1'b0);
        drain();
        repeat (5) @(negedge clk);
        chk("sb_empty", 64'(sbq.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
